// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the ex/clint/bus/debug blocks.
// The master drives the requests; the sequencer (slave) answers with hold/jump/flush/halt.
interface pipe_ctrl_if;
  logic        jump_flag_ex_i;
  logic [31:0] jump_addr_ex_i;
  logic        hold_flag_ex_i;
  logic        hold_flag_rib_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic        dm_halt_req_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        flush_o;
  logic        halted_o;
  logic        hold_timeout_o;

  modport master (
    output jump_flag_ex_i, jump_addr_ex_i, hold_flag_ex_i, hold_flag_rib_i,
    output int_assert_i, int_addr_i, dm_halt_req_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, flush_o, halted_o, hold_timeout_o
  );

  modport slave (
    input  jump_flag_ex_i, jump_addr_ex_i, hold_flag_ex_i, hold_flag_rib_i,
    input  int_assert_i, int_addr_i, dm_halt_req_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, flush_o, halted_o, hold_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: prioritised hold level, jump/flush generation, debug-halt FSM with a
// drain phase, and a watchdog on long non-debug holds.
module pipe_ctrl #(
  parameter int unsigned DRAIN_MIN    = 2,
  parameter int unsigned HOLD_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 11
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave ctrl_io
);

  localparam int unsigned      DrainW    = $clog2(DRAIN_MIN + 2);
  localparam logic [DrainW-1:0] DrainSat = DrainW'(DRAIN_MIN);
  localparam logic [DrainW-1:0] DrainLast = DrainW'((DRAIN_MIN > 0) ? DRAIN_MIN - 1 : 0);
  localparam logic [CNT_W-1:0]  HoldLast = CNT_W'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalted, StResume} state_e;

  state_e              state_q, state_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                halted_q, halted_d;

  logic                jump_flag;
  logic [31:0]         jump_addr;
  logic                flush;
  logic [2:0]          hold_flag;
  logic                wd_active;
  logic                wd_fire;

  // Jump, flush and hold level are combinational so pc_reg loads on the very next edge.
  always_comb begin
    jump_flag = 1'b0;
    jump_addr = '0;
    if (state_q != StHalted) begin
      if (ctrl_io.int_assert_i) begin
        jump_flag = 1'b1;
        jump_addr = ctrl_io.int_addr_i;
      end else if (ctrl_io.jump_flag_ex_i) begin
        jump_flag = 1'b1;
        jump_addr = ctrl_io.jump_addr_ex_i;
      end
    end

    flush = jump_flag | (state_q == StResume);

    if (ctrl_io.hold_flag_ex_i || ctrl_io.int_assert_i || jump_flag ||
        (state_q == StDrain) || (state_q == StHalted)) begin
      hold_flag = 3'd3;
    end else if (ctrl_io.hold_flag_rib_i) begin
      hold_flag = 3'd1;
    end else begin
      hold_flag = 3'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StRun: begin
        if (ctrl_io.dm_halt_req_i) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        if (drain_cnt_q != DrainSat) drain_cnt_d = drain_cnt_q + 1'b1;
        // A withdrawn request aborts the drain straight back to RUN; nothing was stopped.
        if (!ctrl_io.dm_halt_req_i) begin
          state_d = StRun;
        end else if ((drain_cnt_q >= DrainLast) && !ctrl_io.hold_flag_ex_i &&
                     !ctrl_io.int_assert_i) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (!ctrl_io.dm_halt_req_i) state_d = StResume;
      end
      StResume: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Ack only once HALTED has been held for a full cycle; cleared as we leave.
    halted_d = (state_q == StHalted) && (state_d == StHalted);
  end

  always_comb begin
    wd_active  = (hold_flag != 3'd0) && (state_q == StRun);
    wd_fire    = wd_active && (hold_cnt_q == HoldLast);
    hold_cnt_d = (!wd_active || wd_fire) ? '0 : hold_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
      hold_cnt_q  <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign ctrl_io.hold_flag_o    = hold_flag;
  assign ctrl_io.jump_flag_o    = jump_flag;
  assign ctrl_io.jump_addr_o    = jump_addr;
  assign ctrl_io.flush_o        = flush;
  assign ctrl_io.halted_o       = halted_q;
  assign ctrl_io.hold_timeout_o = wd_fire;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed debug/watchdog/reset sequences,
// and random traffic checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int DrainMin = 2;
  localparam int Timeout  = 4;
  localparam int MRun = 0, MDrain = 1, MHalted = 2, MResume = 3;

  typedef struct {
    logic        jex;
    logic [31:0] jaddr;
    logic        hex;
    logic        rib;
    logic        ia;
    logic [31:0] iaddr;
    logic        dm;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [2:0]  hold;
    logic        jf;
    logic [31:0] ja;
    logic        fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .DRAIN_MIN   (DrainMin),
    .HOLD_TIMEOUT(Timeout),
    .CNT_W       (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_io(bus.slave)
  );

  int nvec = 0;
  int nerr = 0;

  // Model: debug mode, cycles spent in that mode (1 on entry), consecutive RUN hold cycles.
  int m_mode, m_age, m_run;

  function automatic stim_t mk(logic jex, logic [31:0] jaddr, logic hex, logic rib, logic ia,
                               logic [31:0] iaddr, logic dm);
    stim_t s;
    s.jex = jex; s.jaddr = jaddr; s.hex = hex; s.rib = rib;
    s.ia = ia; s.iaddr = iaddr; s.dm = dm;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MRun; m_age = 1; m_run = 0;
  endtask

  task automatic model_out(output logic [2:0] h, output logic jf, output logic [31:0] ja,
                           output logic fl, output logic hd, output logic to);
    jf = (m_mode != MHalted) && (bus.int_assert_i || bus.jump_flag_ex_i);
    ja = !jf ? 32'h0 : (bus.int_assert_i ? bus.int_addr_i : bus.jump_addr_ex_i);
    fl = jf || (m_mode == MResume);
    if (bus.hold_flag_ex_i || bus.int_assert_i || jf || m_mode == MDrain || m_mode == MHalted)
      h = 3'd3;
    else
      h = bus.hold_flag_rib_i ? 3'd1 : 3'd0;
    hd = (m_mode == MHalted) && (m_age >= 2);
    to = (h != 3'd0) && (m_mode == MRun) && (((m_run + 1) % Timeout) == 0);
  endtask

  task automatic model_step();
    logic [2:0] h; logic jf, fl, hd, to; logic [31:0] ja;
    int nxt;
    model_out(h, jf, ja, fl, hd, to);
    m_run = (h != 3'd0 && m_mode == MRun) ? m_run + 1 : 0;
    case (m_mode)
      MRun:    nxt = bus.dm_halt_req_i ? MDrain : MRun;
      MDrain:  nxt = !bus.dm_halt_req_i ? MRun :
                     (m_age >= DrainMin && !bus.hold_flag_ex_i && !bus.int_assert_i) ? MHalted
                                                                                     : MDrain;
      MHalted: nxt = bus.dm_halt_req_i ? MHalted : MResume;
      default: nxt = MRun;
    endcase
    m_age  = (nxt == m_mode) ? m_age + 1 : 1;
    m_mode = nxt;
  endtask

  // Apply inputs in the low phase and compare every output against the model.
  task automatic drive(input stim_t s);
    logic [2:0] h; logic jf, fl, hd, to; logic [31:0] ja;
    bus.jump_flag_ex_i  = s.jex;
    bus.jump_addr_ex_i  = s.jaddr;
    bus.hold_flag_ex_i  = s.hex;
    bus.hold_flag_rib_i = s.rib;
    bus.int_assert_i    = s.ia;
    bus.int_addr_i      = s.iaddr;
    bus.dm_halt_req_i   = s.dm;
    #1;
    model_out(h, jf, ja, fl, hd, to);
    chk("model_hold", 32'(bus.hold_flag_o), 32'(h));
    chk("model_jump_flag", 32'(bus.jump_flag_o), 32'(jf));
    chk("model_jump_addr", bus.jump_addr_o, ja);
    chk("model_flush", 32'(bus.flush_o), 32'(fl));
    chk("model_halted", 32'(bus.halted_o), 32'(hd));
    chk("model_timeout", 32'(bus.hold_timeout_o), 32'(to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  vec_t  tbl[8];
  stim_t idle, s;
  logic [9:0] wd_pat;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{s: mk(0, 32'h0,   0, 0, 0, 32'h0,  0), hold: 3'd0, jf: 0, ja: 32'h0,   fl: 0};
    tbl[1] = '{s: mk(1, 32'h100, 0, 1, 0, 32'h0,  0), hold: 3'd3, jf: 1, ja: 32'h100, fl: 1};
    tbl[2] = '{s: mk(0, 32'h100, 0, 1, 0, 32'h0,  0), hold: 3'd1, jf: 0, ja: 32'h0,   fl: 0};
    tbl[3] = '{s: mk(1, 32'h200, 0, 0, 1, 32'h80, 0), hold: 3'd3, jf: 1, ja: 32'h80,  fl: 1};
    tbl[4] = '{s: mk(0, 32'h0,   1, 0, 0, 32'h0,  0), hold: 3'd3, jf: 0, ja: 32'h0,   fl: 0};
    tbl[5] = '{s: mk(0, 32'h0,   0, 1, 1, 32'h44, 0), hold: 3'd3, jf: 1, ja: 32'h44,  fl: 1};
    tbl[6] = '{s: mk(1, 32'h300, 1, 1, 0, 32'h0,  0), hold: 3'd3, jf: 1, ja: 32'h300, fl: 1};
    tbl[7] = '{s: mk(0, 32'h0,   0, 0, 0, 32'h0,  0), hold: 3'd0, jf: 0, ja: 32'h0,   fl: 0};

    // Reset with every input high, then inputs low while still in reset.
    rst = 1'b1;
    bus.jump_flag_ex_i = 1; bus.jump_addr_ex_i = '1; bus.hold_flag_ex_i = 1;
    bus.hold_flag_rib_i = 1; bus.int_assert_i = 1; bus.int_addr_i = '1; bus.dm_halt_req_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_halted", 32'(bus.halted_o), 0);
    chk("rst_timeout", 32'(bus.hold_timeout_o), 0);
    model_reset();
    drive(idle);
    chk("rst_hold", 32'(bus.hold_flag_o), 0);
    chk("rst_jump_flag", 32'(bus.jump_flag_o), 0);
    chk("rst_jump_addr", bus.jump_addr_o, 0);
    chk("rst_flush", 32'(bus.flush_o), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].s);
      chk($sformatf("vec%0d_hold", i), 32'(bus.hold_flag_o), 32'(tbl[i].hold));
      chk($sformatf("vec%0d_jf", i), 32'(bus.jump_flag_o), 32'(tbl[i].jf));
      chk($sformatf("vec%0d_ja", i), bus.jump_addr_o, tbl[i].ja);
      chk($sformatf("vec%0d_flush", i), 32'(bus.flush_o), 32'(tbl[i].fl));
      tick();
    end

    // Halt request while ex is busy: stays draining until ex hold drops.
    for (int i = 0; i < 5; i++) begin
      drive(mk(0, 0, 1, 0, 0, 0, 1));
      chk("dbg_busy_halted", 32'(bus.halted_o), 0);
      chk("dbg_busy_hold", 32'(bus.hold_flag_o), 3);
      tick();
    end
    drive(mk(0, 0, 0, 0, 0, 0, 1));
    chk("dbg_last_drain_halted", 32'(bus.halted_o), 0);
    tick();
    drive(mk(0, 0, 0, 0, 0, 0, 1));
    chk("dbg_halt_entry_halted", 32'(bus.halted_o), 0);
    chk("dbg_halt_entry_hold", 32'(bus.hold_flag_o), 3);
    tick();
    drive(mk(1, 32'h40, 0, 0, 0, 0, 1));
    chk("dbg_halted", 32'(bus.halted_o), 1);
    chk("dbg_halted_jump_ignored", 32'(bus.jump_flag_o), 0);
    chk("dbg_halted_no_flush", 32'(bus.flush_o), 0);
    tick();
    drive(idle);
    chk("dbg_release_halted", 32'(bus.halted_o), 1);
    chk("dbg_release_flush", 32'(bus.flush_o), 0);
    tick();
    drive(idle);
    chk("dbg_resume_flush", 32'(bus.flush_o), 1);
    chk("dbg_resume_halted", 32'(bus.halted_o), 0);
    tick();
    drive(idle);
    chk("dbg_run_flush", 32'(bus.flush_o), 0);
    chk("dbg_run_hold", 32'(bus.hold_flag_o), 0);
    tick();

    // One-cycle halt pulse: a drain cycle, then straight back to RUN.
    drive(mk(0, 0, 0, 0, 0, 0, 1));
    tick();
    drive(idle);
    chk("pulse_drain_hold", 32'(bus.hold_flag_o), 3);
    chk("pulse_drain_flush", 32'(bus.flush_o), 0);
    tick();
    drive(idle);
    chk("pulse_run_hold", 32'(bus.hold_flag_o), 0);
    chk("pulse_run_halted", 32'(bus.halted_o), 0);
    tick();

    // Watchdog: bus stall for 10 cycles fires on the 4th and 8th.
    wd_pat = 10'b0010001000;
    for (int i = 0; i < 10; i++) begin
      drive(mk(0, 0, 0, 1, 0, 0, 0));
      chk($sformatf("wd_cycle%0d", i + 1), 32'(bus.hold_timeout_o), 32'(wd_pat[i]));
      tick();
    end
    drive(idle);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(mk(0, 0, 0, 1, 0, 0, 0));
      chk($sformatf("wd_rearm%0d", i + 1), 32'(bus.hold_timeout_o), 32'(i == 3));
      tick();
    end

    // Reset while halted: halted_o must drop without a clock edge.
    for (int i = 0; i < 4; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 1));
      tick();
    end
    drive(mk(0, 0, 0, 0, 0, 0, 1));
    chk("rsth_halted_before", 32'(bus.halted_o), 1);
    #1 rst = 1'b1;
    #1;
    chk("rsth_halted_async", 32'(bus.halted_o), 0);
    chk("rsth_hold_run", 32'(bus.hold_flag_o), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    drive(idle);
    rst = 1'b0;
    tick();

    // Random traffic with a slowly toggling halt request.
    s = idle;
    for (int i = 0; i < 400; i++) begin
      s.jex   = ($urandom_range(3) == 0);
      s.jaddr = $urandom;
      s.hex   = ($urandom_range(3) == 0);
      s.rib   = ($urandom_range(2) == 0);
      s.ia    = ($urandom_range(9) == 0);
      s.iaddr = $urandom;
      if ($urandom_range(7) == 0) s.dm = ~s.dm;
      drive(s);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
